lights_speed_ctrl: RTL and testbench
====================================

Name: lights_speed_ctrl

Overview:
- Front-panel controller for the external light sequencer.
- Conditions three raw pushbuttons (next, pause, stop) and runs a speed-mode state machine.
- Optionally auto-steps through speeds on a timer.
- Drives the one-hot speed1/speed2/speed3 selects of the clock divider, plus a run enable that gates the light sequencer.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a button level is accepted (10 ms at 50 MHz).
- AUTO_CYCLES, 250000000: cycles per auto-step dwell (5 s at 50 MHz).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_next  input  1  raw pushbutton, asynchronous to clk, active-high
- btn_pause  input  1  raw pushbutton, asynchronous, active-high
- btn_stop  input  1  raw pushbutton, asynchronous, active-high
- auto_en  input  1  level; enables timed auto-stepping (treated as quasi-static, 2-flop synchronized)
- speed1  output  1  slow select to the clock divider
- speed2  output  1  medium select
- speed3  output  1  fast select
- run  output  1  high while lights are advancing
- mode  output  3  current state code

Behaviour:
- One clock and one synchronous, active-high reset. All outputs are registered.
- Reset values: state=STOP, saved=SLOW, all counters 0, debounced levels 0, speed1/2/3=0, run=0, mode=3'd0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level flips only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. The counter clears whenever the synchronized input equals the debounced level.
  - A press pulse is 1 cycle, generated on the debounced rising edge. Releases generate nothing. A held button produces exactly one pulse.
- States and mode codes: STOP=0, SLOW=1, MED=2, FAST=3, HOLD=4.
- Transitions, evaluated each cycle in strict priority order:
  1. stop_press: any state -> STOP. saved is unchanged.
  2. pause_press:
     - SLOW/MED/FAST -> HOLD, with saved <= current state.
     - HOLD -> saved.
     - STOP: no change.
  3. step, where step = next_press OR auto_tick:
     - STOP -> SLOW -> MED -> FAST -> SLOW (wrap; STOP is never re-entered by step).
     - HOLD: step ignored.
- Simultaneous events:
  - Only the highest-priority event takes effect. Lower-priority pulses in the same cycle are discarded, not queued.
  - next_press and auto_tick together produce a single advance.
- Auto timer:
  - Counts only when synchronized auto_en=1 and state is SLOW/MED/FAST.
  - At count AUTO_CYCLES-1, auto_tick pulses for 1 cycle and the counter returns to 0.
  - The counter clears on any state change, when auto_en=0, or in STOP/HOLD. A manual next therefore restarts the full dwell.
- Output decode, loaded on the same edge as the state register:
  - speed1=(SLOW), speed2=(MED), speed3=(FAST).
  - At most one select is high; all are low in STOP/HOLD.
  - run=1 in SLOW/MED/FAST.
  - mode=state code.
- Latency:
  - Press pulse in cycle N: state and outputs change at the edge ending cycle N.
  - Raw button edge to output change: 2 sync + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. There is no overflow: counters always reset at terminal count.
- Reset mid-operation:
  - Takes effect at the next edge regardless of pending pulses or counts.
  - A button held through reset deasserts into debounced=0. If still held, it then produces one pulse after DEBOUNCE_CYCLES.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, AUTO_CYCLES=10.
1. Reset, then hold btn_next high 20 cycles -> exactly one pulse; mode 0->1; speed1=1, run=1; change occurs 7 cycles after btn_next rises.
2. Glitch btn_next high for 3 cycles, low 5, repeated -> mode never changes. Then four clean presses from STOP -> mode 1,2,3,1.
3. In MED, press pause -> mode=4, speeds all 0, run=0. Press next -> stays 4. Press pause -> mode=2, speed2=1.
4. btn_stop and btn_next pulses land in the same cycle while in FAST -> mode=0. In a later test, pause and next coincide in SLOW -> mode=4, saved=SLOW.
5. auto_en=1 in SLOW -> MED exactly 10 cycles later, FAST 10 after, SLOW 10 after. A manual next at cycle 6 of a dwell -> immediate advance, and the next auto step follows 10 cycles later.
6. Assert reset for 1 cycle while in HOLD with a press mid-debounce -> next cycle mode=0, all outputs 0, and no stray pulse from the partial debounce.

Source files
------------

// File: rtl/lights_speed_ctrl.sv
// Front-panel controller for the external light sequencer.
// Conditions three raw pushbuttons (synchronize, debounce, rising-edge pulse),
// runs the STOP/SLOW/MED/FAST/HOLD speed state machine with optional timed
// auto-stepping, and drives registered one-hot speed selects plus run enable.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   btn_next   raw pushbutton, asynchronous, active-high: advance speed
//   btn_pause  raw pushbutton, asynchronous, active-high: hold / resume
//   btn_stop   raw pushbutton, asynchronous, active-high: stop
//   auto_en    quasi-static level enabling timed auto-stepping
//   speed1     slow select to the clock divider
//   speed2     medium select
//   speed3     fast select
//   run        high while lights are advancing
//   mode       current state code (STOP=0 SLOW=1 MED=2 FAST=3 HOLD=4)
module lights_speed_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_CYCLES     = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       btn_stop,
  input  logic       auto_en,
  output logic       speed1,
  output logic       speed2,
  output logic       speed3,
  output logic       run,
  output logic [2:0] mode
);

  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

  // Button index: 0 = next, 1 = pause, 2 = stop
  localparam int unsigned BTN_NEXT  = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam int unsigned BTN_STOP  = 2;

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_SLOW = 3'd1,
    ST_MED  = 3'd2,
    ST_FAST = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_stop, btn_pause, btn_next};

  // Per-button conditioning: 2-flop sync, stable-count debounce, rising-edge pulse
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        deb   <= 1'b0;
        deb_d <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= btn_raw[g];
        sync2 <= sync1;
        deb_d <= deb;
        // Any cycle agreeing with the accepted level restarts the stability count
        if (sync2 == deb) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt <= '0;
          deb <= sync2;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end
    end

    assign press[g] = deb & ~deb_d;
  end

  state_t            state;
  state_t            state_nx;
  state_t            saved;
  state_t            saved_nx;
  logic              auto_s1;
  logic              auto_s2;
  logic [AUTO_W-1:0] auto_cnt;
  logic              active;
  logic              auto_tick;
  logic              step;

  // Next-state logic: stop beats pause beats step; losers in a cycle are dropped
  always_comb begin
    state_nx  = state;
    saved_nx  = saved;
    active    = (state == ST_SLOW) || (state == ST_MED) || (state == ST_FAST);
    auto_tick = auto_s2 && active && (auto_cnt == AUTO_LAST);
    step      = press[BTN_NEXT] | auto_tick;

    if (press[BTN_STOP]) begin
      state_nx = ST_STOP;
    end else if (press[BTN_PAUSE]) begin
      if (active) begin
        state_nx = ST_HOLD;
        saved_nx = state;
      end else if (state == ST_HOLD) begin
        state_nx = saved;
      end
    end else if (step) begin
      case (state)
        ST_STOP: state_nx = ST_SLOW;
        ST_SLOW: state_nx = ST_MED;
        ST_MED:  state_nx = ST_FAST;
        ST_FAST: state_nx = ST_SLOW;
        default: state_nx = state;
      endcase
    end
  end

  // State register with outputs decoded from next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_STOP;
      saved  <= ST_SLOW;
      speed1 <= 1'b0;
      speed2 <= 1'b0;
      speed3 <= 1'b0;
      run    <= 1'b0;
      mode   <= 3'd0;
    end else begin
      state  <= state_nx;
      saved  <= saved_nx;
      speed1 <= (state_nx == ST_SLOW);
      speed2 <= (state_nx == ST_MED);
      speed3 <= (state_nx == ST_FAST);
      run    <= (state_nx == ST_SLOW) || (state_nx == ST_MED) || (state_nx == ST_FAST);
      mode   <= state_nx;
    end
  end

  // Auto-step dwell timer; any state change restarts the full dwell
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_s1  <= 1'b0;
      auto_s2  <= 1'b0;
      auto_cnt <= '0;
    end else begin
      auto_s1 <= auto_en;
      auto_s2 <= auto_s1;
      if (!auto_s2 || !active || auto_tick || (state_nx != state)) begin
        auto_cnt <= '0;
      end else begin
        auto_cnt <= auto_cnt + AUTO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lights_speed_ctrl.sv
// Self-checking bench for lights_speed_ctrl with short debounce/dwell times.
// A behavioural model tracks raw-sample history per button and applies the
// panel rules directly; scenario tasks also check fixed expected timings.
module tb_lights_speed_ctrl;

  localparam int DEB  = 4;
  localparam int AUTO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next;
  logic       btn_pause;
  logic       btn_stop;
  logic       auto_en;
  logic       speed1;
  logic       speed2;
  logic       speed3;
  logic       run;
  logic [2:0] mode;

  int total = 0;
  int bad   = 0;

  lights_speed_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_CYCLES(AUTO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_next(btn_next),
    .btn_pause(btn_pause),
    .btn_stop(btn_stop),
    .auto_en(auto_en),
    .speed1(speed1),
    .speed2(speed2),
    .speed3(speed3),
    .run(run),
    .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_mode  = 0;
  int         m_saved = 1;
  int         m_run   = 0;
  int         ecount  = 0;
  int         rise_edge [3];
  logic [2:0] m_deb = 3'b000;
  logic [3:0] rawq [$];

  // Expected output vector {speed1,speed2,speed3,run,mode} for a mode number
  function automatic logic [6:0] vec_of(input int md);
    return {md == 1, md == 2, md == 3, (md >= 1 && md <= 3), 3'(md)};
  endfunction

  function automatic logic [6:0] expv();
    return vec_of(m_mode);
  endfunction

  // Model: rawq[j] holds raw inputs sampled j+1 edges ago; a button's
  // synchronized view lags the pins by two edges.
  always @(posedge clk) begin : model
    logic [3:0] s;
    logic [3:0] h;
    logic       p_next, p_pause, p_stop, tick, act, all_diff;
    int         nm;
    if (reset) begin
      m_mode  = 0;
      m_saved = 1;
      m_run   = 0;
      m_deb   = 3'b000;
      for (int b = 0; b < 3; b++) rise_edge[b] = -100;
      rawq.delete();
    end else begin
      s       = (rawq.size() > 1) ? rawq[1] : 4'b0000;
      p_next  = (rise_edge[0] == ecount - 1);
      p_pause = (rise_edge[1] == ecount - 1);
      p_stop  = (rise_edge[2] == ecount - 1);
      act     = (m_mode >= 1 && m_mode <= 3);
      tick    = 1'b0;
      if (act && s[3]) begin
        m_run = m_run + 1;
        tick  = (m_run == AUTO);
      end else begin
        m_run = 0;
      end
      nm = m_mode;
      if (p_stop) begin
        nm = 0;
      end else if (p_pause) begin
        if (act) begin
          m_saved = m_mode;
          nm      = 4;
        end else if (m_mode == 4) begin
          nm = m_saved;
        end
      end else if (p_next || tick) begin
        if (m_mode != 4) nm = (m_mode % 3) + 1;
      end
      if (nm != m_mode) m_run = 0;
      m_mode = nm;
      // A level is accepted once the last DEB synchronized samples all disagree
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          h = (rawq.size() > j) ? rawq[j] : 4'b0000;
          if (h[b] == m_deb[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_deb[b] = ~m_deb[b];
          if (m_deb[b]) rise_edge[b] = ecount;
        end
      end
      rawq.push_front({auto_en, btn_stop, btn_pause, btn_next});
      if (rawq.size() > DEB + 2) void'(rawq.pop_back());
    end
    ecount = ecount + 1;
  end

  // Drive-only helpers; all tasks start and end just after a falling edge
  task automatic apply_reset(input int n);
    reset     = 1'b1;
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    btn_stop  = 1'b0;
    auto_en   = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_next  = v;
      1:       btn_pause = v;
      default: btn_stop  = v;
    endcase
  endtask

  task automatic press(input int b, input int hi, input int lo);
    set_btn(b, 1'b1);
    repeat (hi) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000000) begin
      bad++;
      $display("FAIL reset_initial got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000000);
    end
    reset    = 1'b1;
    btn_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({speed1, speed2, speed3, run, mode} !== 7'b0000000) begin
        bad++;
        $display("FAIL reset_held cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, 7'b0000000);
      end
    end
    btn_next = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_hold_press();
    logic [6:0] exp;
    apply_reset(2);
    btn_next = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp = (i >= 7) ? 7'b1001001 : 7'b0000000;
      total++;
      if ({speed1, speed2, speed3, run, mode} !== exp) begin
        bad++;
        $display("FAIL hold_press cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, exp);
      end
      if (i == 20) btn_next = 1'b0;
    end
  endtask

  task automatic test_glitch();
    int hi;
    int seq [4];
    seq = '{1, 2, 3, 1};
    apply_reset(2);
    for (int r = 0; r < 6; r++) begin
      hi       = int'($urandom_range(1, DEB - 1));
      btn_next = 1'b1;
      for (int i = 0; i < hi + 5; i++) begin
        @(negedge clk);
        if (i == hi - 1) btn_next = 1'b0;
        total++;
        if (mode !== 3'd0) begin
          bad++;
          $display("FAIL glitch rep=%0d cyc=%0d got=%0d exp=0", r, i, mode);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      press(0, int'($urandom_range(6, 10)), 8);
      total++;
      if ({speed1, speed2, speed3, run, mode} !== vec_of(seq[k])) begin
        bad++;
        $display("FAIL clean_press n=%0d got=%b exp=%b", k, {speed1, speed2, speed3, run, mode}, vec_of(seq[k]));
      end
    end
  endtask

  task automatic test_pause();
    apply_reset(2);
    press(0, 6, 8);
    press(0, 7, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0101010) begin
      bad++;
      $display("FAIL pause_setup got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0101010);
    end
    press(1, 8, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000100) begin
      bad++;
      $display("FAIL pause_enter got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000100);
    end
    press(0, 6, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000100) begin
      bad++;
      $display("FAIL pause_next_ignored got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000100);
    end
    press(1, 9, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0101010) begin
      bad++;
      $display("FAIL pause_resume got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0101010);
    end
  endtask

  task automatic test_simultaneous();
    int hi;
    logic [6:0] exp;
    apply_reset(2);
    press(0, 6, 8);
    press(0, 6, 8);
    press(0, 6, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0011011) begin
      bad++;
      $display("FAIL simul_setup got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0011011);
    end
    hi        = int'($urandom_range(6, 9));
    btn_stop  = 1'b1;
    btn_next  = 1'b1;
    for (int i = 1; i <= hi + 8; i++) begin
      @(negedge clk);
      exp = (i >= 7) ? 7'b0000000 : 7'b0011011;
      total++;
      if ({speed1, speed2, speed3, run, mode} !== exp) begin
        bad++;
        $display("FAIL stop_vs_next cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, exp);
      end
      if (i == hi) begin
        btn_stop = 1'b0;
        btn_next = 1'b0;
      end
    end
    apply_reset(2);
    press(0, 6, 8);
    btn_pause = 1'b1;
    btn_next  = 1'b1;
    repeat (7) @(negedge clk);
    btn_pause = 1'b0;
    btn_next  = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000100) begin
      bad++;
      $display("FAIL pause_vs_next got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000100);
    end
    press(1, 6, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b1001001) begin
      bad++;
      $display("FAIL saved_slow got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b1001001);
    end
  endtask

  task automatic test_auto();
    int em;
    apply_reset(2);
    auto_en = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (mode !== 3'd0) begin
      bad++;
      $display("FAIL auto_idle_stop got=%0d exp=0", mode);
    end
    btn_next = 1'b1;
    repeat (7) @(negedge clk);
    btn_next = 1'b0;
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b1001001) begin
      bad++;
      $display("FAIL auto_enter_slow got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b1001001);
    end
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (j < 30)      em = ((j / AUTO) % 3) + 1;
      else if (j < 36) em = 1;
      else if (j < 46) em = 2;
      else             em = 3;
      total++;
      if ({speed1, speed2, speed3, run, mode} !== vec_of(em)) begin
        bad++;
        $display("FAIL auto_dwell cyc=%0d got=%b exp=%b", j, {speed1, speed2, speed3, run, mode}, vec_of(em));
      end
      total++;
      if ({speed1, speed2, speed3, run, mode} !== expv()) begin
        bad++;
        $display("FAIL auto_model cyc=%0d got=%b exp=%b", j, {speed1, speed2, speed3, run, mode}, expv());
      end
      if (j == 29) btn_next = 1'b1;
      if (j == 35) btn_next = 1'b0;
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    apply_reset(2);
    press(0, 6, 8);
    press(0, 6, 8);
    press(1, 6, 8);
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000100) begin
      bad++;
      $display("FAIL midreset_setup got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000100);
    end
    btn_next = 1'b1;
    repeat (4) @(negedge clk);
    reset    = 1'b1;
    btn_next = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({speed1, speed2, speed3, run, mode} !== 7'b0000000) begin
      bad++;
      $display("FAIL midreset_outputs got=%b exp=%b", {speed1, speed2, speed3, run, mode}, 7'b0000000);
    end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      total++;
      if ({speed1, speed2, speed3, run, mode} !== 7'b0000000) begin
        bad++;
        $display("FAIL midreset_stray cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, 7'b0000000);
      end
    end
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      exp = (i >= 7) ? 7'b1001001 : 7'b0000000;
      total++;
      if ({speed1, speed2, speed3, run, mode} !== exp) begin
        bad++;
        $display("FAIL held_thru_reset cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, exp);
      end
    end
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    apply_reset(2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++;
      if ({speed1, speed2, speed3, run, mode} !== expv()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {speed1, speed2, speed3, run, mode}, expv());
      end
      if ($urandom_range(0, 11) == 0)  btn_next  = ~btn_next;
      if ($urandom_range(0, 11) == 0)  btn_pause = ~btn_pause;
      if ($urandom_range(0, 39) == 0)  btn_stop  = ~btn_stop;
      if ($urandom_range(0, 149) == 0) auto_en   = ~auto_en;
      reset = ($urandom_range(0, 599) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_next  = 1'b0;
    btn_pause = 1'b0;
    btn_stop  = 1'b0;
    auto_en   = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold_press();
    test_glitch();
    test_pause();
    test_simultaneous();
    test_auto();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
